// File: rtl/trace_pkg.sv
// Shared definitions for the write-back trace UART path.
package trace_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Extra pointer MSB tells full from empty when the indices match.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + (do_push ? (AW+1)'(1) : '0);
        rd_ptr_d = rd_ptr_q + (do_pop ? (AW+1)'(1) : '0);
        dout     = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/wb_trace_uart_tx.sv
// Captures non-zero processor write-back values into a FIFO and sends each as four big-endian 8N1 UART frames.
module wb_trace_uart_tx
    import trace_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] in_write_data,
    input  logic        in_enable,
    output logic        tx,
    output logic        busy,
    output logic        overflow,
    output logic [15:0] word_count
);

    localparam int unsigned    TW   = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  TMAX = TW'(CLKS_PER_BIT - 1);

    tx_state_e   state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]  bit_q, bit_d;
    logic [1:0]  byte_q, byte_d;
    logic [31:0] shift_q, shift_d;
    logic        overflow_q, overflow_d;
    logic [15:0] count_q, count_d;

    logic        fifo_full, fifo_empty, push, pop, capture, bit_end;
    logic [31:0] fifo_dout;
    logic [7:0]  cur_byte;

    sync_fifo #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (Clk),
        .rst_n (Reset_n),
        .push  (push),
        .pop   (pop),
        .din   (in_write_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    always_comb begin
        pop        = (state_q == ST_IDLE) && !fifo_empty;
        capture    = in_enable && (in_write_data != '0);
        push       = capture && (!fifo_full || pop);
        overflow_d = overflow_q | (capture && fifo_full && !pop);
        count_d    = count_q + (push ? 16'd1 : 16'd0);
    end

    always_comb begin
        state_d = state_q;
        timer_d = '0;
        bit_d   = bit_q;
        byte_d  = byte_q;
        shift_d = shift_q;
        bit_end = (timer_q == TMAX);
        if (state_q != ST_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + TW'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    shift_d = fifo_dout;
                    byte_d  = '0;
                    bit_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'(UART_DATA_BITS - 1)) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (byte_q != 2'(BYTES_PER_WORD - 1)) begin
                        byte_d  = byte_q + 2'd1;
                        shift_d = shift_q << UART_DATA_BITS;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // The byte on the wire is always the top of the shift word.
    always_comb begin
        cur_byte = shift_q[31 -: 8];
        case (state_q)
            ST_START: tx = 1'b0;
            ST_DATA:  tx = cur_byte[bit_q];
            default:  tx = 1'b1;
        endcase
        busy       = (state_q != ST_IDLE) || !fifo_empty;
        overflow   = overflow_q;
        word_count = count_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_q      <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

endmodule

// File: doc/wb_trace_uart_tx.md
# wb_trace_uart_tx

Hardware-side write-back tracer for the Processor. Samples the processor's `out_write_data` every cycle, discards zero values, buffers the non-zero values in a FIFO, and serialises each one over a UART TX line. The host therefore receives the same signed write-back stream that the simulation dump records, but from real silicon. The block sits beside `Processor` in the FPGA top level, fed directly from its debug outputs.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868; clock cycles per UART bit (100 MHz / 115200). Minimum legal value is 2.
- `FIFO_DEPTH`, default 16; capture FIFO entries. Must be a power of 2 and at least 2.

Ports:
- `Clk`  in  1  system clock; all logic is on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `in_write_data`  in  32  processor write-back value, sampled every cycle.
- `in_enable`  in  1  capture enable; when low, nothing is pushed.
- `tx`  out  1  UART serial output, 8N1, idle high.
- `busy`  out  1  high while a word is being serialised or the FIFO is non-empty.
- `overflow`  out  1  sticky; set when a non-zero value is dropped because the FIFO is full.
- `word_count`  out  16  count of words accepted into the FIFO; wraps modulo 2^16.

## Operation
- Push condition: `in_enable` high, `in_write_data != 0`, and the FIFO is not full.
  - A cycle in which a pop also occurs counts as not full. Push and pop may happen in the same cycle.
  - On every push, `word_count` increments.
- Drop condition: the push conditions hold except the FIFO is full with no pop that cycle. On a drop, the value is discarded and `overflow` is set to 1. `overflow` is cleared only by reset.
- Transmitter states:
  - IDLE: `tx` = 1. If the FIFO is non-empty, pop one word into the 32-bit shift word, set byte index to 0, and go to START.
  - START: `tx` = 0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: send 8 bits, LSB first, each held for `CLKS_PER_BIT` cycles. Then go to STOP.
  - STOP: `tx` = 1 for `CLKS_PER_BIT` cycles.
    - If byte index is less than 3: increment it and go to START.
    - Otherwise: go to IDLE.
- Byte order is big-endian: byte 0 is `[31:24]` and byte 3 is `[7:0]`.
- A word is 4 frames, 40 bit times in total. There is no idle gap between bytes of the same word.
- `busy` = (state != IDLE) OR FIFO non-empty.

## Timing
- Reset values: `tx` = 1, `busy` = 0, `overflow` = 0, `word_count` = 0, state = IDLE, FIFO empty.
- Push latency: the value present at rising edge N is in the FIFO after edge N. If the transmitter is idle, it is popped at edge N+1, and `tx` falls (start bit) after edge N+1.
- Bit timing:
  - Each bit lasts exactly `CLKS_PER_BIT` cycles.
  - A word occupies 40·`CLKS_PER_BIT` cycles from start-bit fall to the end of the last stop bit.
  - The next word's start bit begins 1 cycle after that, because IDLE costs one cycle.
- Reset asserted mid-frame: `tx` goes to 1 immediately (asynchronously). The FIFO contents and the partial word are lost.
- Sustained input faster than one word per 40·`CLKS_PER_BIT` cycles eventually overflows. This is expected, and `overflow` flags it.

## Structure
- Shared package `trace_pkg`:
  - transmitter state enum (IDLE, START, DATA, STOP)
  - `UART_DATA_BITS` = 8
  - `BYTES_PER_WORD` = 4
- Sub-module `sync_fifo`:
  - parameters: width 32, depth `FIFO_DEPTH`
  - ports: push, pop, din, dout, full, empty
  - uses show-ahead `dout` and supports simultaneous push/pop when full.
- The top holds the capture logic, counters and the TX FSM, including the bit-timer counter, bit index and byte index.

## Test plan
All scenarios use `CLKS_PER_BIT` = 4 and `FIFO_DEPTH` = 4.
1. Reset, then hold `in_write_data` = 0 with `in_enable` = 1 for 100 cycles → `tx` stays 1, `busy` = 0, `word_count` = 0.
2. Single pulse `in_write_data` = 0x12345678 → the UART decoder recovers bytes 0x12, 0x34, 0x56, 0x78. The first start bit falls 1 cycle after the push cycle, and `tx` returns to idle 160 cycles later.
3. Pulse value −5 (0xFFFFFFFB) → bytes 0xFF, 0xFF, 0xFF, 0xFB; the host reassembles the signed value −5.
4. Push 6 consecutive non-zero values, one per cycle, starting while idle → the first value is popped by the FSM 1 cycle after it is written. Values 1 to 5 are accepted and value 6 is dropped, giving `word_count` = 5 and `overflow` = 1. Exactly 5 words are transmitted, in order.
5. Assert `Reset_n` low in the middle of byte 2 → `tx` = 1 without waiting for a clock edge. After release, `overflow` = 0, `word_count` = 0, and no residual bits are sent.
6. `in_enable` = 0 with non-zero data → no push and no count change. Then raise `in_enable` → capture resumes on the first enabled cycle.
